// File: rtl/bus_width_increase.sv
// bus_width_increase: packs narrow SIZE_IN beats into SIZE_OUT words.
// Little-endian lanes; input_last closes a partial word with zero fill.
module bus_width_increase #(
  parameter  int SIZE_IN  = 8,
  parameter  int SIZE_OUT = 32,
  localparam int RATIO    = SIZE_OUT / SIZE_IN
) (
  input  logic                clk,
  input  logic                reset_n,
  output logic                input_ready,
  input  logic                input_valid,
  input  logic                input_last,
  input  logic [SIZE_IN-1:0]  data_in,
  input  logic                output_ready,
  output logic                output_valid,
  output logic                output_last,
  output logic [RATIO-1:0]    output_keep,
  output logic [SIZE_OUT-1:0] data_out
);

  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  generate
    if (RATIO < 2 || (SIZE_OUT % SIZE_IN) != 0) begin : g_bad_ratio
      $error("bus_width_increase: SIZE_OUT/SIZE_IN must be an integer >= 2");
    end
  endgenerate

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t state, state_d;

  logic [SIZE_OUT-1:0] acc_data;
  logic [RATIO-1:0]    acc_keep;
  logic                acc_last;
  logic [IDX_W-1:0]    idx;

  logic [SIZE_OUT-1:0] w_data;
  logic [RATIO-1:0]    w_keep;
  logic                slot_free;
  logic                accept;
  logic                complete;
  logic                load;

  logic [SIZE_OUT-1:0] src_data;
  logic [RATIO-1:0]    src_keep;
  logic                src_last;

  assign input_ready = (state == FILL);
  assign slot_free   = !output_valid || output_ready;
  assign accept      = input_valid && (state == FILL);
  assign complete    = accept && (input_last || idx == LAST_IDX);

  // Accumulator contents with the incoming beat merged into lane idx.
  always_comb begin
    w_data = acc_data;
    w_keep = acc_keep;
    w_data[idx*SIZE_IN +: SIZE_IN] = data_in;
    w_keep[idx] = 1'b1;
  end

  // Word handed to the output register: held word in HOLD, else live merge.
  always_comb begin
    src_data = w_data;
    src_keep = w_keep;
    src_last = input_last;
    if (state == HOLD) begin
      src_data = acc_data;
      src_keep = acc_keep;
      src_last = acc_last;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= FILL;
    end else begin
      state <= state_d;
    end
  end

  // Next state and output-register load decision.
  always_comb begin
    state_d = state;
    load    = 1'b0;
    unique case (state)
      FILL: begin
        if (complete) begin
          if (slot_free) begin
            load = 1'b1;
          end else begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (slot_free) begin
          load    = 1'b1;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // Accumulator: merge beats, clear once the word leaves for the output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_data <= '0;
      acc_keep <= '0;
      acc_last <= 1'b0;
      idx      <= '0;
    end else if (load) begin
      acc_data <= '0;
      acc_keep <= '0;
      acc_last <= 1'b0;
      idx      <= '0;
    end else if (accept) begin
      acc_data <= w_data;
      acc_keep <= w_keep;
      acc_last <= input_last;
      if (!complete) begin
        idx <= idx + 1'b1;
      end
    end
  end

  // Output register: loads a finished word, drops valid once consumed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      output_valid <= 1'b0;
      output_last  <= 1'b0;
      output_keep  <= '0;
      data_out     <= '0;
    end else if (load) begin
      output_valid <= 1'b1;
      output_last  <= src_last;
      output_keep  <= src_keep;
      data_out     <= src_data;
    end else if (output_ready) begin
      output_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bus_width_increase.sv
// tb_bus_width_increase: directed vectors plus multi-cycle sequences
// for the 8->32 beat packer.
module tb_bus_width_increase;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        input_ready;
  logic        input_valid = 1'b0;
  logic        input_last = 1'b0;
  logic [7:0]  data_in = '0;
  logic        output_ready = 1'b0;
  logic        output_valid;
  logic        output_last;
  logic [3:0]  output_keep;
  logic [31:0] data_out;

  bus_width_increase #(
    .SIZE_IN (8),
    .SIZE_OUT(32)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .input_ready (input_ready),
    .input_valid (input_valid),
    .input_last  (input_last),
    .data_in     (data_in),
    .output_ready(output_ready),
    .output_valid(output_valid),
    .output_last (output_last),
    .output_keep (output_keep),
    .data_out    (data_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  d;
    logic        l;
    logic        done;
    logic [31:0] xd;
    logic [3:0]  xk;
    logic        xl;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } word_t;

  int total = 0;
  int bad = 0;
  int stab_err = 0;
  word_t got[$];
  logic prod_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic l, output int waited);
    logic rdy;
    input_valid = 1'b1;
    data_in = d;
    input_last = l;
    waited = 0;
    forever begin
      @(negedge clk);
      rdy = input_ready;
      @(posedge clk);
      #1;
      if (rdy) break;
      waited++;
      if (waited > 200) begin
        total++;
        bad++;
        $display("FAIL send_timeout: beat %h not accepted", d);
        break;
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    logic hold_prev;
    word_t last_w;
    hold_prev = 1'b0;
    last_w = '{32'h0, 4'h0, 1'b0};
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        hold_prev = 1'b0;
      end else begin
        if (hold_prev && (data_out !== last_w.d || output_keep !== last_w.k
                          || output_last !== last_w.l))
          stab_err++;
        if (output_valid && output_ready)
          got.push_back('{data_out, output_keep, output_last});
        hold_prev = output_valid && !output_ready;
        last_w = '{data_out, output_keep, output_last};
      end
    end
  end

  initial begin : main
    vec_t vt[14];
    logic [31:0] exp_q[$];
    logic [31:0] w;
    int wt;
    int maxw;
    int base;
    int n;

    vt = '{
      '{8'h11, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0},
      '{8'h22, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0},
      '{8'h33, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0},
      '{8'h44, 1'b0, 1'b1, 32'h44332211, 4'hF, 1'b0},
      '{8'hAA, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0},
      '{8'hBB, 1'b1, 1'b1, 32'h0000BBAA, 4'h3, 1'b1},
      '{8'hCC, 1'b1, 1'b1, 32'h000000CC, 4'h1, 1'b1},
      '{8'h01, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0},
      '{8'h02, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0},
      '{8'h03, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0},
      '{8'h04, 1'b1, 1'b1, 32'h04030201, 4'hF, 1'b1},
      '{8'hD1, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0},
      '{8'hD2, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0},
      '{8'hD3, 1'b1, 1'b1, 32'h00D3D2D1, 4'h7, 1'b1}
    };

    tick(2);
    check("rst_valid", output_valid, 1'b0);
    check("rst_data", data_out, 32'h0);
    check("rst_keep", output_keep, 4'h0);
    check("rst_last", output_last, 1'b0);
    reset_n = 1'b1;
    tick(1);
    check("rst_ready", input_ready, 1'b1);

    output_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      send(vt[i].d, vt[i].l, wt);
      check($sformatf("tv%0d_valid", i), output_valid, vt[i].done);
      if (vt[i].done) begin
        check($sformatf("tv%0d_data", i), data_out, vt[i].xd);
        check($sformatf("tv%0d_keep", i), output_keep, vt[i].xk);
        check($sformatf("tv%0d_last", i), output_last, vt[i].xl);
      end
    end
    input_valid = 1'b0;
    input_last = 1'b0;
    tick(1);
    check("tv_drain_valid", output_valid, 1'b0);

    send(8'h11, 1'b0, wt);
    send(8'h22, 1'b0, wt);
    input_valid = 1'b0;
    tick(5);
    check("gap_valid", output_valid, 1'b0);
    send(8'h33, 1'b0, wt);
    send(8'h44, 1'b0, wt);
    input_valid = 1'b0;
    check("gap_data", data_out, 32'h44332211);
    check("gap_keep", output_keep, 4'hF);

    tick(1);
    output_ready = 1'b0;
    for (int i = 1; i <= 8; i++) send(8'(i), 1'b0, wt);
    input_valid = 1'b0;
    check("hold_ready", input_ready, 1'b0);
    check("hold_valid", output_valid, 1'b1);
    check("hold_data1", data_out, 32'h04030201);
    tick(3);
    check("hold_data1_stable", data_out, 32'h04030201);
    check("hold_ready_stable", input_ready, 1'b0);
    output_ready = 1'b1;
    tick(1);
    check("hold_data2", data_out, 32'h08070605);
    check("hold_keep2", output_keep, 4'hF);
    check("hold_valid2", output_valid, 1'b1);
    check("hold_ready_back", input_ready, 1'b1);
    tick(1);
    check("hold_valid_drop", output_valid, 1'b0);

    output_ready = 1'b0;
    send(8'h11, 1'b0, wt);
    send(8'h12, 1'b0, wt);
    send(8'h13, 1'b0, wt);
    send(8'h14, 1'b0, wt);
    send(8'h21, 1'b0, wt);
    send(8'h22, 1'b0, wt);
    input_valid = 1'b0;
    check("prerst_valid", output_valid, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_valid", output_valid, 1'b0);
    check("arst_data", data_out, 32'h0);
    check("arst_keep", output_keep, 4'h0);
    check("arst_ready", input_ready, 1'b1);
    #4 reset_n = 1'b1;
    tick(1);
    output_ready = 1'b1;
    send(8'h5A, 1'b0, wt);
    send(8'h6B, 1'b0, wt);
    send(8'h7C, 1'b0, wt);
    send(8'h8D, 1'b0, wt);
    input_valid = 1'b0;
    check("post_rst_valid", output_valid, 1'b1);
    check("post_rst_data", data_out, 32'h8D7C6B5A);
    check("post_rst_keep", output_keep, 4'hF);
    check("post_rst_last", output_last, 1'b0);
    tick(2);

    base = got.size();
    maxw = 0;
    for (int i = 0; i < 40; i++) begin
      send(8'(i * 7 + 3), 1'b0, wt);
      if (wt > maxw) maxw = wt;
    end
    input_valid = 1'b0;
    tick(2);
    check("tput_stall", maxw, 0);
    check("tput_count", got.size() - base, 10);
    for (int j = 0; j < 10 && base + j < got.size(); j++) begin
      for (int k = 0; k < 4; k++) w[k*8 +: 8] = 8'((j * 4 + k) * 7 + 3);
      check($sformatf("tput_w%0d", j), got[base+j].d, w);
    end

    base = got.size();
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          w = $urandom;
          exp_q.push_back(w);
          for (int k = 0; k < 4; k++) send(w[k*8 +: 8], 1'b0, wt);
        end
        input_valid = 1'b0;
        prod_done = 1'b1;
      end
      begin
        while (!prod_done) begin
          @(posedge clk);
          #1;
          output_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    output_ready = 1'b1;
    n = 0;
    while (got.size() - base < 100 && n < 50) begin
      tick(1);
      n++;
    end
    check("chain_count", got.size() - base, 100);
    for (int i = 0; i < 100 && base + i < got.size(); i++) begin
      check($sformatf("chain_w%0d", i), got[base+i].d, exp_q[i]);
      check($sformatf("chain_k%0d", i), got[base+i].k, 4'hF);
    end

    tick(2);
    check("hold_stable", stab_err, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
